cic_sample_buffer: RTL and testbench
====================================

Name: cic_sample_buffer

Overview:
- Sits directly downstream of the 3rd-order CIC decimator (D=256, 25-bit unsigned output).
- Captures each decimated word once per decimation period, in the modulator clock domain, and discards CIC start-up transients.
- Converts each word to signed 16-bit (midscale removal, shift, optional rounding, saturation).
- Buffers words in a small FIFO and presents them on a valid/ready stream to the readout/register block.

Parameters:
- DECIMATION, 256, CIC decimation ratio; power of two.
- CAPTURE_PHASE, 128, phase-counter value at which cic_in is sampled.
- SHIFT, 8, arithmetic right shift applied after midscale removal.
- SETTLE, 3, number of captures discarded after enable rises.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  modulator clock; the same clock that drives the CIC.
- reset_n  in  1  asynchronous, active-low reset; shared with the CIC.
- enable  in  1  synchronous run enable.
- cic_in  in  25  CIC output word, unsigned, range 0..2^24.
- sample_out  out  16  signed two's-complement sample at the FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts the head word.
- fifo_level  out  $clog2(DEPTH+1)  number of stored words.
- overflow  out  1  sticky flag: a sample was dropped.
- overflow_clr  in  1  one-cycle pulse; clears overflow and drop_count.
- drop_count  out  8  dropped-sample count; saturates at 255.

Behaviour:
- Single clock domain. Every flop uses posedge clk and asynchronous clear on negedge reset_n.
- Reset values: sample_out=0, sample_valid=0, fifo_level=0, overflow=0, drop_count=0. Phase counter=0, settle counter=0, state=IDLE.
- Phase counter: $clog2(DECIMATION) bits, free-running, increments every cycle from reset, wraps DECIMATION-1→0. It is not gated by enable, so it stays locked to the CIC counter, which shares the same reset.
- Capture strobe: phase counter == CAPTURE_PHASE. cic_in is guaranteed stable there, about half a period away from the CIC output update.
- State machine:
  - IDLE: enable=0. FIFO is held empty and the settle counter is 0. Goes to SETTLE when enable=1.
  - SETTLE: each capture strobe increments the settle counter. After the SETTLE-th strobe, goes to RUN; that strobe's word is discarded.
  - RUN: each strobe launches a word into the processing pipeline.
  - enable=0 in any state returns to IDLE next cycle. FIFO and any in-flight pipeline word are flushed. overflow and drop_count are retained.
- Processing:
  - Stage 1 (strobe cycle +1): d = {1'b0,cic_in} - 2^23, 26-bit signed.
  - Stage 2 (+2): s = d >>> SHIFT (arithmetic). Saturate to [-32768, 32767], then FIFO write.
- Latency: a RUN strobe makes sample_valid rise 3 cycles after the strobe cycle when the FIFO was empty.
- FIFO:
  - Show-ahead: sample_out always shows the head word. sample_out holds its last value when empty.
  - Pop when sample_valid && sample_ready.
  - Write while full and no pop: the new word is dropped, overflow sets, drop_count increments (saturating at 255). Stored contents are unchanged.
  - Write and pop in the same cycle while full: both occur, nothing is dropped, level is unchanged.
  - Write and pop in the same cycle while empty: no bypass. The word is stored, level becomes 1.
- overflow_clr and a new drop in the same cycle: set wins, overflow=1 and drop_count=1.
- Reset mid-operation: all state returns to reset values immediately, including the phase counter, keeping it re-aligned with the CIC.

Optional Feature:
- Macro: CIC_SAMPLE_BUFFER_ROUND_EN.
- Defined: stage 2 adds 2^(SHIFT-1) to d before the shift (round half up), then saturates.
- Undefined: plain truncation toward minus infinity.
- Latency is identical in both builds.

Test Plan:
- Midscale: enable=1, cic_in=8388608, sample_ready=1. First 3 strobes produce no output; then one word per 256 clk, sample_out=0, valid rising 3 cycles after the strobe.
- Full-scale: cic_in=16777216 → 32767 (saturated). cic_in=0 → -32768. cic_in=8388608+256 → 1.
- Rounding: cic_in=8388608+128 → 1 with CIC_SAMPLE_BUFFER_ROUND_EN defined, 0 without. cic_in=8388608-1 → 0 with, -1 without.
- Overflow: after settling, hold sample_ready=0 for 6 RUN strobes → fifo_level=4, overflow=1, drop_count=2. Pop order returns the first 4 words. A one-cycle overflow_clr then gives overflow=0, drop_count=0.
- Enable drop: with 2 words stored, deassert enable → next cycle fifo_level=0, sample_valid=0. Re-enable → 3 strobes discarded before the next output.
- Reset mid-stream: assert reset_n=0 mid-period with 3 words stored → all outputs read 0 immediately. After release, the phase counter restarts at 0 and the first capture occurs 128 cycles later.

Source files
------------

// File: rtl/cic_sample_buffer.sv
// rtl/cic_sample_buffer.sv - CIC decimator capture, 16-bit conversion and show-ahead output FIFO.
// Define CIC_SAMPLE_BUFFER_ROUND_EN to round half up before the shift instead of truncating.
module cic_sample_buffer #(
  parameter int DECIMATION    = 256,
  parameter int CAPTURE_PHASE = 128,
  parameter int SHIFT         = 8,
  parameter int SETTLE        = 3,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [24:0]                  cic_in,
  output logic [15:0]                  sample_out,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  input  logic                         overflow_clr,
  output logic [7:0]                   drop_count
);

  localparam int PW = $clog2(DECIMATION);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

  state_t            state, state_d;
  logic [SW-1:0]     settle_cnt, settle_d;
  logic [PW-1:0]     phase;
  logic              strobe;
  logic              launch;

  // Free-running so it stays locked to the CIC's own counter (same reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase <= '0;
    else          phase <= phase + PW'(1);
  end

  assign strobe = (phase == PW'(CAPTURE_PHASE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_d;
    end
  end

  always_comb begin
    state_d  = state;
    settle_d = settle_cnt;
    launch   = 1'b0;
    case (state)
      ST_IDLE: begin
        settle_d = '0;
        if (enable) state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (strobe) begin
          settle_d = settle_cnt + SW'(1);
          if (settle_cnt == SW'(SETTLE - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN:  launch = strobe;
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      launch   = 1'b0;
    end
  end

  logic               v1, v2;
  logic signed [25:0] d1;
  logic signed [26:0] d_adj, shifted;
  logic        [15:0] sat, s2;

  always_comb begin
`ifdef CIC_SAMPLE_BUFFER_ROUND_EN
    d_adj = 27'(d1) + 27'(2 ** (SHIFT - 1));
`else
    d_adj = 27'(d1);
`endif
    shifted = d_adj >>> SHIFT;
    sat     = shifted[15:0];
    if (shifted > 27'sd32767)       sat = 16'h7fff;
    else if (shifted < -27'sd32768) sat = 16'h8000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      s2 <= '0;
    end else if (!enable) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= launch;
      v2 <= v1;
      if (launch) d1 <= $signed({1'b0, cic_in}) - 26'sd8388608;
      if (v1)     s2 <= sat;
    end
  end

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [LW-1:0] level, level_next;
  logic [15:0]   head_next;
  logic          pop, full, we, drop;

  assign sample_valid = (level != '0);
  assign fifo_level   = level;
  assign pop          = sample_valid && sample_ready;
  assign full         = (level == LW'(DEPTH));
  assign we           = v2 && (!full || pop);
  assign drop         = v2 && enable && full && !pop;
  assign rd_next      = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    level_next = level;
    if (we && !pop)      level_next = level + LW'(1);
    else if (!we && pop) level_next = level - LW'(1);
    // When the write lands exactly at the new head slot, the written word is the head.
    head_next = (we && (rd_next == wr_ptr)) ? s2 : mem[rd_next];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      sample_out <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!enable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (we) begin
        mem[wr_ptr] <= s2;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      level  <= level_next;
      if (level_next != '0) sample_out <= head_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (overflow_clr)              drop_count <= 8'd1;
      else if (drop_count != 8'hff)  drop_count <= drop_count + 8'd1;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_cic_sample_buffer.sv
// tb/tb_cic_sample_buffer.sv - directed self-checking bench for cic_sample_buffer.
// Expectations follow the CIC_SAMPLE_BUFFER_ROUND_EN setting of the build.
module tb_cic_sample_buffer;

  localparam int BASE = 8388608;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [24:0] cic_in;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr;
  logic [7:0]  drop_count;

  int n_asserts = 0;
  int n_fail    = 0;
  int ph        = 0;

  cic_sample_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cic_in       (cic_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 256;
  endtask

  task automatic goto(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ph != p && n < 300);
    chk("goto_bound", int'(ph == p), 1);
  endtask

  function automatic int sval();
    return int'($signed(sample_out));
  endfunction

  task automatic check_word(input string tag, input int cic, input int exp);
    cic_in = 25'(cic);
    goto(131);
    chk({tag, "_valid"}, int'(sample_valid), 1);
    chk(tag, sval(), exp);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; cic_in = '0; sample_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_out", sval(), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);

    // Midscale: three discarded strobes, then output 3 cycles after the strobe.
    reset_n = 1'b1; ph = 0;
    enable = 1'b1; cic_in = 25'(BASE); sample_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      goto(131);
      chk("settle_discard", int'(sample_valid), 0);
    end
    goto(130);
    chk("latency_pre", int'(sample_valid), 0);
    tick();
    chk("latency_valid", int'(sample_valid), 1);
    chk("midscale", sval(), 0);
    tick();
    chk("midscale_popped", int'(sample_valid), 0);

    check_word("full_scale", 16777216, 32767);
    check_word("zero_scale", 0, -32768);
    check_word("plus_one", BASE + 256, 1);
    check_word("minus_lsb256", BASE - 256, -1);
`ifdef CIC_SAMPLE_BUFFER_ROUND_EN
    check_word("half_lsb", BASE + 128, 1);
    check_word("minus_one", BASE - 1, 0);
    check_word("plus_1000", BASE + 1000, 4);
`else
    check_word("half_lsb", BASE + 128, 0);
    check_word("minus_one", BASE - 1, -1);
    check_word("plus_1000", BASE + 1000, 3);
`endif
    check_word("minus_1000", BASE - 1000, -4);

    // Overflow: six strobes with no consumer.
    sample_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cic_in = 25'(BASE + i * 256);
      goto(131);
      if (i == 4) begin
        chk("full_level", int'(fifo_level), 4);
        chk("full_no_overflow", int'(overflow), 0);
      end
    end
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drop_count", int'(drop_count), 2);
    sample_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", int'(sample_valid), 1);
      chk("drain_order", sval(), k);
      tick();
    end
    chk("drain_empty", int'(sample_valid), 0);
    chk("hold_last", sval(), 4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_drop_count", int'(drop_count), 0);

    // Enable drop with two stored words, then re-settle.
    sample_ready = 1'b0;
    cic_in = 25'(BASE + 7 * 256);
    goto(131);
    cic_in = 25'(BASE + 8 * 256);
    goto(131);
    chk("two_stored", int'(fifo_level), 2);
    chk("two_head", sval(), 7);
    enable = 1'b0;
    tick();
    chk("disable_level", int'(fifo_level), 0);
    chk("disable_valid", int'(sample_valid), 0);
    enable = 1'b1;
    cic_in = 25'(BASE + 9 * 256);
    for (int k = 0; k < 3; k++) begin
      goto(131);
      chk("resettle_discard", int'(sample_valid), 0);
    end
    goto(131);
    chk("resettle_valid", int'(sample_valid), 1);
    chk("resettle_value", sval(), 9);

    // Reset mid-period with three stored words.
    cic_in = 25'(BASE + 10 * 256);
    goto(131);
    cic_in = 25'(BASE + 11 * 256);
    goto(131);
    chk("three_stored", int'(fifo_level), 3);
    goto(200);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_sample_out", sval(), 0);
    chk("midrst_valid", int'(sample_valid), 0);
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_drop_count", int'(drop_count), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1; ph = 0;
    enable = 1'b1; sample_ready = 1'b1; cic_in = 25'(BASE + 5 * 256);
    for (int k = 0; k < 3; k++) begin
      goto(131);
      chk("post_rst_discard", int'(sample_valid), 0);
    end
    goto(130);
    chk("post_rst_pre", int'(sample_valid), 0);
    tick();
    chk("post_rst_valid", int'(sample_valid), 1);
    chk("post_rst_value", sval(), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
